// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequencing controller for the 2D weight-stationary MAC array.
// One start runs kernel load, skew settle, activation streaming and result drain.
// Optional build macro MAC_ARRAY_CTRL_TIMEOUT_EN adds a drain-timeout counter
// that raises a sticky err flag and forces completion; without it err is 0.
module mac_array_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int LEN_BW = 8,
  parameter int TO_BW  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_BW-1:0] cfg_len,
  input  logic              cfg_data_mode,
  input  logic              cfg_mode,
  input  logic              fifo_empty,
  input  logic [col-1:0]    valid,
  output logic [1:0]        inst_w,
  output logic              data_mode,
  output logic              mode,
  output logic              rd_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_BW-1:0] out_cnt
);

  // One counter is shared by LOAD, SETTLE and EXEC, so it must hold the largest limit.
  localparam int SETTLE_MAX = row + col;
  localparam int CNT_BW = ($clog2(SETTLE_MAX + 1) > LEN_BW) ? $clog2(SETTLE_MAX + 1) : LEN_BW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_BW-1:0] r_cnt;
  logic [LEN_BW-1:0] r_len;
  logic [LEN_BW-1:0] r_out_cnt;
  logic [1:0]        r_inst_w;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;
  logic              r_data_mode;
  logic              r_mode;
  // A start is registered first; the FSM acts on it one edge later.
  logic              r_start_q;
  logic              r_zero_q;

  logic              w_issue;
  logic              w_result;
  logic [CNT_BW-1:0] w_settle_len;
  logic [CNT_BW-1:0] w_len_ext;
  logic              w_unused;

  assign w_issue      = ~fifo_empty;
  assign w_result     = valid[col-1] && ((r_state == S_EXEC) || (r_state == S_DRAIN));
  assign w_settle_len = r_data_mode ? CNT_BW'(col) : CNT_BW'(SETTLE_MAX);
  assign w_len_ext    = CNT_BW'(r_len);
  // Only the last column's valid marks a result leaving the south edge.
  assign w_unused     = &{1'b0, valid[col-2:0]};

`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
  localparam logic [TO_BW-1:0] TO_LIMIT = TO_BW'(2 * (row + col));
  logic [TO_BW-1:0] r_to_cnt;
  logic             r_err;
`endif

  // Main sequencer: state, counters and every registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_out_cnt   <= '0;
      r_inst_w    <= 2'b00;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_data_mode <= 1'b0;
      r_mode      <= 1'b0;
      r_start_q   <= 1'b0;
      r_zero_q    <= 1'b0;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_inst_w  <= 2'b00;
      r_rd_en   <= 1'b0;
      r_start_q <= 1'b0;
      r_zero_q  <= 1'b0;
      if (w_result && (r_out_cnt != r_len)) begin
        r_out_cnt <= r_out_cnt + LEN_BW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (r_start_q) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_cnt   <= w_issue ? CNT_BW'(1) : '0;
            if (w_issue) begin
              r_inst_w <= 2'b01;
              r_rd_en  <= 1'b1;
            end
          end else if (r_zero_q) begin
            r_state <= S_DONE;
            r_busy  <= 1'b1;
            r_done  <= 1'b1;
          end else if (start) begin
            if (cfg_len != '0) begin
              r_len       <= cfg_len;
              r_data_mode <= cfg_data_mode;
              r_mode      <= cfg_mode;
              r_out_cnt   <= '0;
              r_start_q   <= 1'b1;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
              r_err       <= 1'b0;
`endif
            end else begin
              r_zero_q <= 1'b1;
            end
          end
        end
        // r_cnt counts accepted cycles including the one being issued.
        S_LOAD: begin
          if (r_cnt == CNT_BW'(col)) begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_BW'(1);
          end else if (w_issue) begin
            r_inst_w <= 2'b01;
            r_rd_en  <= 1'b1;
            r_cnt    <= r_cnt + CNT_BW'(1);
          end
        end
        S_SETTLE: begin
          if (r_cnt == w_settle_len) begin
            r_state <= S_EXEC;
            r_cnt   <= w_issue ? CNT_BW'(1) : '0;
            if (w_issue) begin
              r_inst_w <= 2'b10;
              r_rd_en  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_BW'(1);
          end
        end
        S_EXEC: begin
          if (r_cnt == w_len_ext) begin
            r_state  <= S_DRAIN;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end else if (w_issue) begin
            r_inst_w <= 2'b10;
            r_rd_en  <= 1'b1;
            r_cnt    <= r_cnt + CNT_BW'(1);
          end
        end
        S_DRAIN: begin
          if (r_out_cnt == r_len) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
          else if (valid[col-1]) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt == TO_LIMIT - TO_BW'(1)) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_BW'(1);
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
  assign err = r_err;
`else
  logic [TO_BW-1:0] w_unused_to;
  assign w_unused_to = '0;
  assign err         = 1'b0;
`endif

  assign inst_w    = r_inst_w;
  assign rd_en     = r_rd_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign data_mode = r_data_mode;
  assign mode      = r_mode;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed testbench for mac_array_ctrl with an expectation scoreboard.
module tb_mac_array_ctrl;
  localparam int ROW    = 8;
  localparam int COL    = 8;
  localparam int LEN_BW = 8;
  localparam int TO_BW  = 12;

  logic              clk;
  logic              reset;
  logic              start;
  logic [LEN_BW-1:0] cfg_len;
  logic              cfg_data_mode;
  logic              cfg_mode;
  logic              fifo_empty;
  logic [COL-1:0]    valid;
  logic [1:0]        inst_w;
  logic              data_mode;
  logic              mode;
  logic              rd_en;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_BW-1:0] out_cnt;

  mac_array_ctrl #(.row(ROW), .col(COL), .LEN_BW(LEN_BW), .TO_BW(TO_BW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .cfg_data_mode(cfg_data_mode), .cfg_mode(cfg_mode), .fifo_empty(fifo_empty),
    .valid(valid), .inst_w(inst_w), .data_mode(data_mode), .mode(mode),
    .rd_en(rd_en), .busy(busy), .done(done), .err(err), .out_cnt(out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   stall_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int t0      = 0;
  int rd_cnt, load_cyc, exec_cyc, done_cnt, done_cyc, first_load, first_exec, rd_mis;
  logic [2:0] vpipe;
  int vtap;
  int vbudget;

  task automatic check(input string tag, input int obs, input int expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic int measured(input string tag);
    case (tag)
      "load_rel":     return first_load - t0;
      "exec_gap":     return first_exec - first_load;
      "load_cycles":  return load_cyc;
      "exec_cycles":  return exec_cyc;
      "rd_pulses":    return rd_cnt;
      "done_rel":     return done_cyc - t0;
      "done_count":   return done_cnt;
      "out_cnt":      return int'(out_cnt);
      "err":          return int'(err);
      "busy":         return int'(busy);
      "data_mode":    return int'(data_mode);
      "mode":         return int'(mode);
      "rd_inst_mis":  return rd_mis;
      default:        return -1;
    endcase
  endfunction

  // One clock: sample outputs 1 ns after the edge, then drive the next inputs.
  task automatic tick();
    logic vbit;
    logic [COL-2:0] noise;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_en === 1'b1) rd_cnt++;
    if (rd_en !== (inst_w != 2'b00)) rd_mis++;
    if (inst_w === 2'b01) begin
      load_cyc++;
      if (first_load < 0) first_load = cyc;
    end
    if (inst_w === 2'b10) begin
      exec_cyc++;
      if (first_exec < 0) first_exec = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    vpipe = {vpipe[1:0], (inst_w == 2'b10)};
    vbit = vpipe[vtap] && (vbudget > 0);
    if (vbit) vbudget--;
    noise = (COL-1)'($urandom);
    valid = {vbit, noise};
    fifo_empty = 1'b0;
    foreach (stall_q[i]) if (stall_q[i] == cyc) fifo_empty = 1'b1;
  endtask

  task automatic clear_stats(input int tap, input int budget);
    rd_cnt = 0; load_cyc = 0; exec_cyc = 0; done_cnt = 0; rd_mis = 0;
    done_cyc = -1; first_load = -1; first_exec = -1;
    vpipe = '0; vtap = tap; vbudget = budget;
    stall_q.delete();
  endtask

  task automatic start_pass(input int len, input logic dm, input logic md);
    cfg_len = LEN_BW'(len);
    cfg_data_mode = dm;
    cfg_mode = md;
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; poke_cyc >= 0 injects a start with altered config there.
  task automatic run_until_done(input int budget, input int poke_cyc);
    int lim;
    lim = cyc + budget;
    while (done_cnt == 0 && cyc < lim) begin
      tick();
      if (cyc == poke_cyc) begin
        start = 1'b1;
        cfg_len = LEN_BW'(7);
        cfg_data_mode = ~cfg_data_mode;
        cfg_mode = ~cfg_mode;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic score();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, measured(e.tag), e.val);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_data_mode = 1'b0; cfg_mode = 1'b0;
    fifo_empty = 1'b0; valid = '0;
    clear_stats(2, 0);
    repeat (3) tick();
    check("rst_inst_w", int'(inst_w), 0);
    check("rst_data_mode", int'(data_mode), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    reset = 1'b0;
    tick();

    // Nominal: LOAD at t0+2, EXEC 24 later, last exec t0+29, last result counted t0+32, done t0+33.
    $display("nominal pass cfg_len=4 data_mode=0");
    clear_stats(2, 4);
    expect_val("load_rel", 2); expect_val("exec_gap", 24); expect_val("load_cycles", 8);
    expect_val("exec_cycles", 4); expect_val("rd_pulses", 12); expect_val("done_rel", 33);
    expect_val("done_count", 1); expect_val("out_cnt", 4); expect_val("err", 0);
    expect_val("data_mode", 0); expect_val("mode", 0); expect_val("rd_inst_mis", 0);
    start_pass(4, 1'b0, 1'b0);
    run_until_done(120, -1);
    score();

    // Stalls: two LOAD bubbles and one EXEC bubble delay everything by 3 cycles.
    $display("stall pass cfg_len=3");
    clear_stats(2, 3);
    stall_q.push_back(cyc + 3); stall_q.push_back(cyc + 4); stall_q.push_back(cyc + 28);
    expect_val("load_cycles", 8); expect_val("exec_cycles", 3); expect_val("rd_pulses", 11);
    expect_val("exec_gap", 26); expect_val("done_rel", 35); expect_val("done_count", 1);
    expect_val("out_cnt", 3); expect_val("rd_inst_mis", 0);
    start_pass(3, 1'b0, 1'b0);
    run_until_done(120, -1);
    score();

    // Broadcast: SETTLE is 8; results arrive during EXEC so DRAIN is a single cycle.
    $display("broadcast pass cfg_len=2 data_mode=1 mode=1");
    clear_stats(0, 2);
    expect_val("exec_gap", 16); expect_val("data_mode", 1); expect_val("mode", 1);
    expect_val("rd_pulses", 10); expect_val("exec_cycles", 2); expect_val("done_rel", 21);
    expect_val("out_cnt", 2); expect_val("done_count", 1);
    start_pass(2, 1'b1, 1'b1);
    run_until_done(120, -1);
    score();

    $display("zero-length start");
    clear_stats(0, 0);
    expect_val("done_rel", 2); expect_val("rd_pulses", 0); expect_val("done_count", 1);
    start_pass(0, 1'b0, 1'b0);
    run_until_done(20, -1);
    score();

    // A start with new config during EXEC (t0+28) must change nothing.
    $display("ignored start during exec cfg_len=3");
    clear_stats(2, 3);
    expect_val("rd_pulses", 11); expect_val("exec_cycles", 3); expect_val("out_cnt", 3);
    expect_val("done_rel", 32); expect_val("done_count", 1); expect_val("data_mode", 0);
    expect_val("mode", 0); expect_val("busy", 0);
    start_pass(3, 1'b0, 1'b0);
    run_until_done(120, t0 + 28);
    repeat (10) tick();
    score();

    $display("reset during settle");
    clear_stats(2, 4);
    start_pass(4, 1'b0, 1'b0);
    while (cyc < t0 + 12) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_inst_w", int'(inst_w), 0);
    check("mid_rst_rd_en", int'(rd_en), 0);
    check("mid_rst_out_cnt", int'(out_cnt), 0);
    reset = 1'b0;
    repeat (40) tick();
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_idle", int'(busy), 0);

    // Only one of two results ever arrives (during EXEC); DRAIN starts at t0+28.
    $display("drain timeout cfg_len=2 one result");
    clear_stats(0, 1);
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
    expect_val("done_rel", 60); expect_val("err", 1); expect_val("out_cnt", 1);
    expect_val("done_count", 1); expect_val("busy", 0);
    start_pass(2, 1'b0, 1'b0);
    run_until_done(150, -1);
    score();
`else
    expect_val("done_count", 0); expect_val("busy", 1); expect_val("err", 0);
    expect_val("out_cnt", 1);
    start_pass(2, 1'b0, 1'b0);
    run_until_done(100, -1);
    score();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencing controller for the 2D MAC array. After one `start` it runs a complete weight-stationary pass over the array:

- kernel load through `in_w`;
- a fixed skew-settle wait;
- streaming of `cfg_len` activation vectors;
- draining until every result has left the south edge.

It drives the array's `inst_w`, `data_mode` and `mode` inputs, pulls data from the west-side input FIFO, and watches the array's `valid` bus to detect completion.

## Interface

Parameters:
- `row`, 8: array rows.
- `col`, 8: array columns.
- `LEN_BW`, 8: width of the vector-count configuration.
- `TO_BW`, 12: width of the drain timeout counter.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle request to begin a pass; sampled only in IDLE.
- `cfg_len`, input, `LEN_BW`: number of activation vectors to stream; latched on accepted `start`.
- `cfg_data_mode`, input, 1: 1 = broadcast instructions to all rows, 0 = skewed instructions; latched on `start`.
- `cfg_mode`, input, 1: array arithmetic mode; latched on `start`.
- `fifo_empty`, input, 1: west input FIFO has no data.
- `valid`, input, `col`: array south-edge valid bus.
- `inst_w`, output, 2: bit1 = execute, bit0 = kernel load; drives the array.
- `data_mode`, output, 1: latched `cfg_data_mode`.
- `mode`, output, 1: latched `cfg_mode`.
- `rd_en`, output, 1: pop strobe to the west input FIFO.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: sticky drain-timeout flag. Always present; tied to 0 unless timeout is enabled.
- `out_cnt`, output, `LEN_BW`: number of result vectors observed so far.

## Operation

States: IDLE, LOAD, SETTLE, EXEC, DRAIN, DONE.

- **IDLE**
  - `start=1` with `cfg_len!=0` latches the configuration, clears `out_cnt` and `err`, and goes to LOAD.
  - `start=1` with `cfg_len==0` goes to DONE directly.
- **LOAD**
  - Each cycle with `fifo_empty=0`: `inst_w=01`, `rd_en=1`, and the load counter increments.
  - Each cycle with `fifo_empty=1`: `inst_w=00`, `rd_en=0`, and the counter holds.
  - After `col` accepted cycles, go to SETTLE.
- **SETTLE**
  - `inst_w=00`, `rd_en=0`.
  - Lasts `row+col` cycles when `data_mode=0`, or `col` cycles when `data_mode=1`.
  - Then go to EXEC.
- **EXEC**
  - Each cycle with `fifo_empty=0`: `inst_w=10`, `rd_en=1`, and the vector counter increments.
  - Each cycle with `fifo_empty=1`: `inst_w=00`, `rd_en=0`, and the counter holds.
  - After `cfg_len` accepted vectors, go to DRAIN.
- **DRAIN**
  - `inst_w=00`, `rd_en=0`.
  - When `out_cnt==cfg_len`, go to DONE.
- **DONE**
  - `done=1` for exactly one cycle, then IDLE.
- **Result counting**
  - `out_cnt` increments on every cycle with `valid[col-1]=1` in EXEC or DRAIN.
  - It saturates at the latched `cfg_len`.
  - It holds its value through DONE and IDLE until the next accepted `start`.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `cfg_*` changes after latching have no effect.
- **Reset**
  - Takes effect in any state on the next edge.
  - A pass in flight is abandoned; no `done` is produced.

## Timing

- Reset values: state IDLE, `inst_w=00`, `data_mode=0`, `mode=0`, `rd_en=0`, `busy=0`, `done=0`, `err=0`, `out_cnt=0`.
- All outputs are registered; state-dependent outputs change on the edge that enters the state.
- `start` accepted at edge N: `busy=1` and the first LOAD cycle appear after edge N+1.
- `rd_en` and `inst_w` are mutually consistent every cycle: `rd_en=1` if and only if `inst_w!=00`.
- With no FIFO stalls and `data_mode=0`, EXEC is entered exactly `col+row+col` cycles after LOAD is entered.
- `done` is asserted the cycle after `out_cnt` reaches `cfg_len` in DRAIN.
- If the final result arrives while still in EXEC, DRAIN lasts one cycle.

## Configuration

- Macro: `MAC_ARRAY_CTRL_TIMEOUT_EN`.
- **Defined:**
  - A `TO_BW`-bit counter runs in DRAIN.
  - It clears whenever `valid[col-1]=1`.
  - On reaching `2*(row+col)` it sets `err=1` and forces DONE (`done` still pulses).
  - `err` stays set until the next accepted `start` or `reset`.
- **Undefined:**
  - No counter is built and `err` is constant 0.
  - DRAIN waits indefinitely for results.

## Test plan

All scenarios use `row=col=8`.

- **Nominal pass:** reset, then `start` with `cfg_len=4`, `cfg_data_mode=0`, FIFO never empty, and 4 `valid[7]` pulses → `inst_w=01` for 8 cycles, then 16 cycles of `00`, then `10` for 4 cycles; `rd_en` totals 12; `done` pulses once; `out_cnt=4`.
- **Stalls:** `cfg_len=3` with `fifo_empty=1` for 2 cycles in LOAD and 1 cycle in EXEC → load counter and vector counter hold during stalls; still exactly 8 load and 3 execute `rd_en` pulses; `done` is delayed 3 cycles relative to the nominal pass.
- **Broadcast and zero length:** `cfg_data_mode=1` gives SETTLE=8 cycles and `data_mode=1` output. Separately, `start` with `cfg_len=0` → `done` 2 cycles after `start`, with no `rd_en` pulse.
- **Ignored start and mid-pass reset:** `start` while in EXEC → ignored. `reset` asserted in SETTLE → next cycle IDLE, `busy=0`, `inst_w=00`, no `done`.
- **Drain timeout:** with `MAC_ARRAY_CTRL_TIMEOUT_EN` defined, `cfg_len=2` and only 1 `valid[7]` pulse → `err=1` and `done` pulse 32 cycles into DRAIN. Without the macro, the controller stays in DRAIN with `busy=1`.
